// File: rtl/regfile_ctx.sv
// NREGS x DATA_W register file with narrow/wide read ports, swap, carry-immediate rule,
// optional write-to-read bypass and a valid/ready context save/restore engine.
module regfile_ctx #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int R1_ADDR_W = 2,
  parameter int IMM_REG   = 1,
  parameter int BYPASS    = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 write_ctrl,
  input  logic                 carry_out,
  input  logic                 swap_ctrl,
  input  logic [R1_ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0]    read_reg2,
  input  logic [ADDR_W-1:0]    write_reg,
  input  logic [DATA_W-1:0]    write_val,
  output logic [DATA_W-1:0]    read_val1,
  output logic [DATA_W-1:0]    read_val2,
  output logic [DATA_W-1:0]    branch_val,
  input  logic                 ctx_start,
  input  logic                 ctx_restore,
  output logic                 ctx_busy,
  output logic                 ctx_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data
);
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IMM_A  = ADDR_W'(IMM_REG);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_RESTORE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0]  regs_q [NREGS];
  logic [DATA_W-1:0]  regs_d [NREGS];

  logic [ADDR_W-1:0]  ra1;
  logic               idle, wr_en, sw_en;
  logic [DATA_W-1:0]  wr_data, st1, st2;

  assign ra1     = ADDR_W'(read_reg1);
  assign idle    = (state_q == S_IDLE);
  assign wr_en   = write_ctrl && idle;
  assign sw_en   = swap_ctrl && idle;
  assign wr_data = (carry_out && (write_reg == IMM_A)) ? DATA_W'(1) : write_val;
  assign st1     = regs_q[ra1];
  assign st2     = regs_q[read_reg2];

  // Later assignments override earlier ones: carry beats write, swap beats both.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[write_reg] = write_val;
      if (carry_out) regs_d[IMM_A] = DATA_W'(1);
    end
    if (sw_en) begin
      regs_d[ra1]       = st2;
      regs_d[read_reg2] = st1;
    end
    if ((state_q == S_RESTORE) && in_valid) regs_d[idx_q] = in_data;
    regs_d[0] = '0;
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= FIRST_A;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (ctx_start) begin
          state_d = ctx_restore ? S_RESTORE : S_SAVE;
          idx_d   = FIRST_A;
        end
      end
      S_SAVE, S_RESTORE: begin
        if ((state_q == S_SAVE) ? out_ready : in_valid) begin
          if (idx_q == LAST_A) begin
            state_d = S_DONE;
            idx_d   = FIRST_A;
          end else begin
            idx_d = idx_q + FIRST_A;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ctx_busy  = 1'b0;
    ctx_done  = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    case (state_q)
      S_SAVE: begin
        ctx_busy  = 1'b1;
        out_valid = 1'b1;
        out_addr  = idx_q;
        out_data  = regs_q[idx_q];
      end
      S_RESTORE: begin
        ctx_busy = 1'b1;
        in_ready = 1'b1;
      end
      S_DONE:  ctx_done = 1'b1;
      default: ;
    endcase
  end

  // Forwarding covers normal writes only; swap and restore results appear after the edge.
  assign read_val1  = ((BYPASS != 0) && wr_en && (write_reg != '0) && (write_reg == ra1))
                      ? wr_data : st1;
  assign read_val2  = ((BYPASS != 0) && wr_en && (write_reg != '0) && (write_reg == read_reg2))
                      ? wr_data : st2;
  assign branch_val = regs_q[LAST_A];

endmodule

// File: tb/tb_regfile_ctx.sv
// Scoreboard bench for regfile_ctx: a BYPASS=0 instance plus a BYPASS=1 shadow on the same inputs.
module tb_regfile_ctx;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, write_ctrl, carry_out, swap_ctrl;
  logic [1:0] read_reg1;
  logic [2:0] read_reg2, write_reg;
  logic [7:0] write_val, in_data;
  logic       ctx_start, ctx_restore, out_ready, in_valid;

  logic [7:0] rv1, rv2, bv, out_data;
  logic       busy, ctx_done, out_valid, in_ready;
  logic [2:0] out_addr;

  logic [7:0] b_rv1, b_rv2, b_bv, b_out_data;
  logic       b_busy, b_done, b_out_valid, b_in_ready;
  logic [2:0] b_out_addr;

  regfile_ctx #(.DATA_W(8), .ADDR_W(3), .R1_ADDR_W(2), .IMM_REG(1), .BYPASS(0)) dut (
    .clock(clock), .reset_n(reset_n), .write_ctrl(write_ctrl), .carry_out(carry_out),
    .swap_ctrl(swap_ctrl), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_val(write_val), .read_val1(rv1), .read_val2(rv2),
    .branch_val(bv), .ctx_start(ctx_start), .ctx_restore(ctx_restore), .ctx_busy(busy),
    .ctx_done(ctx_done), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  regfile_ctx #(.DATA_W(8), .ADDR_W(3), .R1_ADDR_W(2), .IMM_REG(1), .BYPASS(1)) dut_byp (
    .clock(clock), .reset_n(reset_n), .write_ctrl(write_ctrl), .carry_out(carry_out),
    .swap_ctrl(swap_ctrl), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_val(write_val), .read_val1(b_rv1), .read_val2(b_rv2),
    .branch_val(b_bv), .ctx_start(ctx_start), .ctx_restore(ctx_restore), .ctx_busy(b_busy),
    .ctx_done(b_done), .out_valid(b_out_valid), .out_ready(out_ready), .out_addr(b_out_addr),
    .out_data(b_out_data), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data)
  );

  typedef struct { string name; int sel; logic [7:0] expv; } chk_t;
  typedef struct { logic [2:0] a; logic [7:0] d; } beat_t;
  chk_t  rq[$];
  beat_t sq[$];
  int n_cmp = 0, n_bad = 0, done_cnt = 0, cyc_cnt = 0, last_acc = 0;

  task automatic cmp(string name, logic [7:0] act, logic [7:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] actual(int sel);
    case (sel)
      0:  return rv1;
      1:  return rv2;
      2:  return bv;
      3:  return out_data;
      4:  return {7'b0, busy};
      5:  return 8'(done_cnt);
      6:  return b_rv2;
      7:  return {7'b0, out_valid};
      8:  return {7'b0, in_ready};
      9:  return {5'b0, out_addr};
      10: return {7'b0, ctx_done};
      default: return 8'hxx;
    endcase
  endfunction

  task automatic push(string n, int s, logic [7:0] e);
    rq.push_back('{name: n, sel: s, expv: e});
  endtask

  // Monitor: samples mid-high-phase, between input drive (+1) and the falling active edge (+5).
  always @(posedge clock) begin
    chk_t  c;
    beat_t b;
    #3;
    cyc_cnt++;
    while (rq.size() > 0) begin
      c = rq.pop_front();
      cmp(c.name, actual(c.sel), c.expv);
    end
    if (out_valid && out_ready) begin
      if (sq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL save_extra_beat: got addr 0x%0h, expected no beat", out_addr);
      end else begin
        b = sq.pop_front();
        cmp("save_addr", {5'b0, out_addr}, {5'b0, b.a});
        cmp("save_data", out_data, b.d);
      end
      last_acc = cyc_cnt;
    end
    if (in_valid && in_ready) last_acc = cyc_cnt;
    if (ctx_done) begin
      done_cnt++;
      cmp("done_latency", 8'(cyc_cnt - last_acc), 8'd1);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    write_ctrl = 1'b0;
    carry_out  = 1'b0;
    swap_ctrl  = 1'b0;
    ctx_start  = 1'b0;
  endtask

  task automatic wr(logic [2:0] a, logic [7:0] v);
    cyc();
    quiet();
    write_ctrl = 1'b1;
    write_reg  = a;
    write_val  = v;
  endtask

  task automatic chk_reg(string n, logic [2:0] a, logic [7:0] e);
    cyc();
    quiet();
    read_reg2 = a;
    push(n, 1, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    reset_n = 1'b0;
    quiet();
    read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_val = '0;
    ctx_restore = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_data = '0;

    cyc();
    read_reg1 = 2'd3;
    read_reg2 = 3'd5;
    push("rst_rv1", 0, 0); push("rst_rv2", 1, 0); push("rst_branch", 2, 0);
    push("rst_out_data", 3, 0); push("rst_busy", 4, 0); push("rst_out_valid", 7, 0);
    push("rst_in_ready", 8, 0); push("rst_out_addr", 9, 0); push("rst_done", 10, 0);
    cyc();
    reset_n = 1'b1;

    wr(3'd0, 8'hAA);
    chk_reg("r0_write_ignored", 3'd0, 8'h00);

    wr(3'd7, 8'h77);
    cyc(); quiet(); push("branch_val", 2, 8'h77);
    cyc(); reset_n = 1'b0; push("branch_async_rst", 2, 8'h00);
    cyc(); reset_n = 1'b1;
    chk_reg("r7_after_rst", 3'd7, 8'h00);

    wr(3'd1, 8'h99);
    chk_reg("r1_plain", 3'd1, 8'h99);
    cyc(); quiet(); write_ctrl = 1'b1; carry_out = 1'b1; write_reg = 3'd3; write_val = 8'h5C;
    chk_reg("carry_imm", 3'd1, 8'h01);
    chk_reg("carry_dst", 3'd3, 8'h5C);
    wr(3'd1, 8'h99);
    cyc(); quiet(); write_ctrl = 1'b1; carry_out = 1'b1; write_reg = 3'd1; write_val = 8'h42;
    chk_reg("carry_self", 3'd1, 8'h01);

    wr(3'd2, 8'h11);
    wr(3'd6, 8'h66);
    cyc(); quiet(); swap_ctrl = 1'b1; read_reg1 = 2'd2; read_reg2 = 3'd6;
    push("port1_read", 0, 8'h11);
    chk_reg("swap_r2", 3'd2, 8'h66);
    chk_reg("swap_r6", 3'd6, 8'h11);
    wr(3'd2, 8'h11);
    wr(3'd6, 8'h66);
    cyc(); quiet(); swap_ctrl = 1'b1; read_reg1 = 2'd2; read_reg2 = 3'd6;
    write_ctrl = 1'b1; write_reg = 3'd6; write_val = 8'hFF;
    chk_reg("conflict_r6", 3'd6, 8'h11);
    chk_reg("conflict_r2", 3'd2, 8'h66);
    cyc(); quiet(); swap_ctrl = 1'b1; read_reg1 = 2'd2; read_reg2 = 3'd2;
    chk_reg("swap_equal", 3'd2, 8'h66);

    cyc(); quiet(); write_ctrl = 1'b1; write_reg = 3'd4; write_val = 8'h3C; read_reg2 = 3'd4;
    push("nobyp_old", 1, 8'h00); push("byp_fwd", 6, 8'h3C);
    cyc(); quiet(); push("nobyp_after", 1, 8'h3C); push("byp_after", 6, 8'h3C);
    wr(3'd1, 8'h20);
    cyc(); quiet(); write_ctrl = 1'b1; carry_out = 1'b1; write_reg = 3'd1; write_val = 8'h42;
    read_reg2 = 3'd1;
    push("nobyp_imm", 1, 8'h20); push("byp_imm", 6, 8'h01);

    for (int a = 1; a < 8; a++) wr(3'(a), 8'(a));
    cyc(); quiet(); ctx_start = 1'b1; ctx_restore = 1'b0; out_ready = 1'b0;
    for (int a = 1; a < 8; a++) sq.push_back('{a: 3'(a), d: 8'(a)});
    base = done_cnt;
    for (int i = 0; i < 40; i++) begin
      cyc(); quiet();
      if (done_cnt != base) break;
      out_ready = (i % 2 == 0);
      if (i == 0) begin push("save_busy", 4, 1); push("save_valid", 7, 1); end
      if (i == 2) begin write_ctrl = 1'b1; write_reg = 3'd5; write_val = 8'hEE; end
    end
    out_ready = 1'b0;
    cmp("save_done_count", 8'(done_cnt), 8'(base + 1));
    cmp("save_beats_left", 8'(sq.size()), 8'd0);
    chk_reg("busy_write_dropped", 3'd5, 8'h05);

    cyc(); quiet(); ctx_start = 1'b1; ctx_restore = 1'b1; in_valid = 1'b0;
    base = done_cnt;
    k = 1;
    for (int i = 0; i < 40; i++) begin
      cyc(); quiet();
      if (done_cnt != base) break;
      if (i == 0) push("restore_in_ready", 8, 1);
      if (k <= 7 && (i % 3) != 1) begin
        in_valid = 1'b1; in_data = 8'(8'hA0 + k); k++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    cmp("restore_done_count", 8'(done_cnt), 8'(base + 1));
    for (int a = 1; a < 8; a++) chk_reg("restore_reg", 3'(a), 8'(8'hA0 + a));

    cyc(); quiet(); ctx_start = 1'b1; ctx_restore = 1'b1; in_valid = 1'b0;
    base = done_cnt;
    k = 1;
    for (int i = 0; i < 40; i++) begin
      cyc(); quiet();
      if (k == 4) break;
      if ((i % 3) != 1) begin
        in_valid = 1'b1; in_data = 8'(8'hB0 + k); k++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    push("abort_busy", 4, 0); push("abort_in_ready", 8, 0);
    cyc(); reset_n = 1'b1;
    cyc(); push("abort_idle", 4, 0);
    cyc(); cyc();
    cmp("abort_no_done", 8'(done_cnt), 8'(base));
    chk_reg("abort_r1", 3'd1, 8'h00);
    chk_reg("abort_r3", 3'd3, 8'h00);
    chk_reg("abort_r7", 3'd7, 8'h00);
    cyc(); quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
